niossys_keys_pio: RTL and testbench

Avalon-MM slave input port for the Nios II system: samples `WIDTH` external push-buttons, synchronises and debounces them, and latches edges into a capture register. It raises a maskable level interrupt to the CPU, so the password-checker firmware can read key presses without polling. It sits on the system interconnect beside the LED output port and uses the same register-access style: zero-wait-state reads, writes qualified by `chipselect`/`write_n`.

---
 rtl/niossys_pio_pkg.sv | 23 ++
 rtl/niossys_debounce.sv | 48 ++++
 rtl/niossys_keys_pio.sv | 83 ++++++++
 tb/tb_niossys_keys_pio.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/niossys_pio_pkg.sv
// ---------------------------------------------------------------------------
// niossys_pio_pkg : register map shared by the Nios II PIO blocks
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package niossys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  function automatic logic reg_write(input logic       cs,
                                     input logic       wr_n,
                                     input logic [1:0] addr,
                                     input logic [1:0] target);
    return cs && !wr_n && (addr == target);
  endfunction

endpackage

`default_nettype wire

// File: rtl/niossys_debounce.sv
// ---------------------------------------------------------------------------
// niossys_debounce : two-flop synchroniser plus counting debouncer, one bit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module niossys_debounce #(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic db
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The count only advances while the synchronised level disagrees with db,
  // so any disagreement shorter than DEBOUNCE_CYCLES is forgotten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
      db    <= RESET_LEVEL;
      cnt   <= '0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/niossys_keys_pio.sv
// ---------------------------------------------------------------------------
// niossys_keys_pio : debounced key input port with edge capture and IRQ
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module niossys_keys_pio
  import niossys_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 250000,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1,
  parameter bit               EDGE_RISING     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_clr;
  logic             mask_wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    niossys_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (in_port[i]),
      .db       (db[i])
    );
  end

  assign edge_det     = EDGE_RISING ? (~db_d & db) : (db_d & ~db);
  assign mask_wr      = reg_write(chipselect, write_n, address, ADDR_IRQMASK);
  assign cap_clr      = reg_write(chipselect, write_n, address, ADDR_EDGECAP)
                        ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  // db_d resets to the same level as db so reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_d     <= RESET_LEVEL;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      db_d <= db;
      if (mask_wr) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      // A new edge wins over a clear landing in the same cycle.
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = db;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

`default_nettype wire

// File: tb/tb_niossys_keys_pio.sv
// ---------------------------------------------------------------------------
// tb_niossys_keys_pio : register vectors, directed key sequences, random run
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_niossys_keys_pio;

  localparam int W = 4;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  niossys_keys_pio #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .RESET_LEVEL     (4'hF),
    .EDGE_RISING     (1'b0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  // Reference model: key level accepted after the delayed input holds a new
  // value for D consecutive edges.
  logic [W-1:0] m_dl1, m_dl2, m_prev, m_db, m_dbd, m_mask, m_cap;
  int           m_run[W];

  task automatic model_reset();
    m_dl1 = '1; m_dl2 = '1; m_prev = '1; m_db = '1; m_dbd = '1;
    m_mask = '0; m_cap = '0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_db};
      2'd2:    return {28'b0, m_mask};
      2'd3:    return {28'b0, m_cap};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_step(input logic [W-1:0] in_v, input logic cs, input logic wn,
                            input logic [1:0] a, input logic [31:0] wd);
    logic [W-1:0] s, nd, fall, clr;
    s    = m_dl2;
    fall = m_dbd & ~m_db;
    nd   = m_db;
    for (int b = 0; b < W; b++) begin
      m_run[b] = (s[b] == m_prev[b]) ? m_run[b] + 1 : 1;
      if (s[b] != m_db[b] && m_run[b] >= D) nd[b] = ~m_db[b];
    end
    m_prev = s;
    clr    = (cs && !wn && a == 2'd3) ? wd[W-1:0] : '0;
    m_cap  = (m_cap & ~clr) | fall;
    if (cs && !wn && a == 2'd2) m_mask = wd[W-1:0];
    m_dbd = m_db;
    m_db  = nd;
    m_dl2 = m_dl1;
    m_dl1 = in_v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
    check(name, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic irq_check(input string name, input logic exp);
    #1;
    check(name, {31'b0, irq}, {31'b0, exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 2'd0, 32'h0,        32'hF, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 2'd3, 32'h0,        32'h0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 32'hFFFFFFFA, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 32'h0,        32'hA, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 32'h0,        32'hF, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 32'h0,        32'hF, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'd1, 32'hFF,       32'h0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'd3, 32'hF,        32'h0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 2'd3, 32'h0,        32'h0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 32'hF,        32'hA, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'hA, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 2'd2, 32'h0,        32'hA, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 2'd2, 32'h0,        32'h0, 1'b0};

    reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'h0;
    tick(3);
    reset_n = 1'b1;

    rd_check("reset_data", 2'd0, 32'hF);
    rd_check("reset_irqmask", 2'd2, 32'h0);
    rd_check("reset_edgecap", 2'd3, 32'h0);
    irq_check("reset_irq", 1'b0);

    for (int i = 0; i < 16; i++) begin
      chipselect = vecs[i].cs; write_n = vecs[i].wn;
      address = vecs[i].addr; writedata = vecs[i].wd;
      #1;
      check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
      @(posedge clk);
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
    end

    // Glitch of 5 cycles
    in_port = 4'hE;
    tick(5);
    in_port = 4'hF;
    tick(12);
    rd_check("glitch_data", 2'd0, 32'hF);
    rd_check("glitch_edgecap", 2'd3, 32'h0);

    // Press bit0 with IRQ enabled
    wr(2'd2, 32'h1);
    in_port = 4'hE;
    tick(9);
    rd_check("press_data_early", 2'd0, 32'hF);
    tick(1);
    rd_check("press_data", 2'd0, 32'hE);
    rd_check("press_cap_early", 2'd3, 32'h0);
    irq_check("press_irq_early", 1'b0);
    tick(1);
    rd_check("press_cap", 2'd3, 32'h1);
    irq_check("press_irq", 1'b1);
    wr(2'd3, 32'h1);
    irq_check("clear_irq", 1'b0);
    rd_check("clear_cap", 2'd3, 32'h0);
    tick(10);
    rd_check("hold_no_recapture", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(12);
    rd_check("release_data", 2'd0, 32'hF);
    rd_check("release_no_capture", 2'd3, 32'h0);

    // Masked press of bit2
    in_port = 4'hB;
    tick(11);
    rd_check("masked_cap", 2'd3, 32'h4);
    irq_check("masked_irq", 1'b0);
    wr(2'd2, 32'h5);
    irq_check("unmask_irq", 1'b1);
    wr(2'd3, 32'h4);
    irq_check("masked_clear_irq", 1'b0);
    in_port = 4'hF;
    tick(12);

    // Clear lands on the same edge that sets bit1
    in_port = 4'hD;
    tick(10);
    wr(2'd3, 32'h2);
    rd_check("collision_cap", 2'd3, 32'h2);
    wr(2'd3, 32'h2);
    rd_check("collision_clear", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(12);

    // Reset in the middle of a bit3 debounce
    in_port = 4'h7;
    tick(5);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    rd_check("rst_mid_data", 2'd0, 32'hF);
    rd_check("rst_mid_cap", 2'd3, 32'h0);
    rd_check("rst_mid_mask", 2'd2, 32'h0);
    tick(9);
    rd_check("rst_mid_data_early", 2'd0, 32'hF);
    rd_check("rst_mid_cap_early", 2'd3, 32'h0);
    tick(1);
    rd_check("rst_mid_data_late", 2'd0, 32'h7);
    tick(1);
    rd_check("rst_mid_cap_late", 2'd3, 32'h8);

    // Random traffic against the reference model
    reset_n = 1'b0; in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 15) == 0) in_port[b] = ~in_port[b];
      chipselect = ($urandom_range(0, 7) != 0);
      write_n    = ($urandom_range(0, 5) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      #1;
      check("rand_readdata", readdata, model_read(address));
      check("rand_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
      @(posedge clk);
      model_step(in_port, chipselect, write_n, address, writedata);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
